// File: rtl/sm3_pad_blocker.sv
`default_nettype none
// ============================================================================
// Module      : sm3_pad_blocker
// Description : SM3 message padder and block former. Takes DIN_W-bit message
//               beats MSB-first, appends '1', zero fill and the 64-bit bit
//               length, and emits 512-bit blocks on a valid/ready interface
//               with a final-block flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sm3_pad_blocker #(
  parameter int DIN_W = 32,
  parameter int NB_W  = $clog2(DIN_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_valid,
  input  logic              din_last,
  input  logic [NB_W-1:0]   din_nbits,
  output logic              din_ready,
  output logic [511:0]      blk,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic              blk_last
);

  // Left shift that places a beat at the top of the 512-bit buffer.
  localparam int C_TOP_SH = 512 - DIN_W;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_FULL = 2'd1,
    S_OVF  = 2'd2,
    S_LAST = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [511:0]  r_blk, w_blk_nxt;
  logic [9:0]    r_p, w_p_nxt;
  logic [63:0]   r_len, w_len_nxt;
  logic          r_ext_one, w_ext_one_nxt;
  logic          r_din_ready, r_blk_valid, r_blk_last;

  logic              w_acc;
  logic              w_hs;
  logic [NB_W-1:0]   w_n;
  logic [DIN_W-1:0]  w_mask;
  logic [511:0]      w_beat_sh;
  logic [9:0]        w_pn;
  logic [63:0]       w_lf;
  logic [511:0]      w_mark;

  // din_ready is high exactly in FILL, so an accept implies the FILL state.
  assign w_acc = din_valid && r_din_ready;
  assign w_hs  = r_blk_valid && blk_ready;

  // Non-last beats are always full width; the last beat keeps its top n bits.
  assign w_n       = din_last ? din_nbits : NB_W'(DIN_W);
  assign w_mask    = ~({DIN_W{1'b1}} >> w_n);
  assign w_beat_sh = (512'(din & w_mask) << C_TOP_SH) >> r_p;
  assign w_pn      = r_p + 10'(w_n);
  assign w_lf      = r_len + 64'(w_n);
  // Padding '1' lands right after the last message bit, if it fits here.
  assign w_mark    = (w_pn < 10'd512) ? (512'd1 << (10'd511 - w_pn)) : '0;

  // Next-state and datapath update for fill, overflow and block hand-off.
  always_comb begin
    w_state_nxt   = r_state;
    w_blk_nxt     = r_blk;
    w_p_nxt       = r_p;
    w_len_nxt     = r_len;
    w_ext_one_nxt = r_ext_one;
    case (r_state)
      S_FILL: begin
        if (w_acc) begin
          w_len_nxt = w_lf;
          if (!din_last) begin
            w_blk_nxt = r_blk | w_beat_sh;
            w_p_nxt   = w_pn;
            if (w_pn == 10'd512) w_state_nxt = S_FULL;
          end else begin
            w_blk_nxt = r_blk | w_beat_sh | w_mark;
            if (w_pn <= 10'd447) begin
              w_blk_nxt[63:0] = w_lf;
              w_state_nxt     = S_LAST;
            end else begin
              // Marker already placed unless the message filled the block.
              w_ext_one_nxt = (w_pn == 10'd512);
              w_state_nxt   = S_OVF;
            end
          end
        end
      end
      S_FULL: begin
        if (w_hs) begin
          w_blk_nxt   = '0;
          w_p_nxt     = '0;
          w_state_nxt = S_FILL;
        end
      end
      S_OVF: begin
        if (w_hs) begin
          w_blk_nxt        = '0;
          w_blk_nxt[511]   = r_ext_one;
          w_blk_nxt[63:0]  = r_len;
          w_state_nxt      = S_LAST;
        end
      end
      S_LAST: begin
        if (w_hs) begin
          w_blk_nxt   = '0;
          w_p_nxt     = '0;
          w_len_nxt   = '0;
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // State, buffer and registered handshake outputs derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FILL;
      r_blk       <= '0;
      r_p         <= '0;
      r_len       <= '0;
      r_ext_one   <= 1'b0;
      r_din_ready <= 1'b0;
      r_blk_valid <= 1'b0;
      r_blk_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_blk       <= w_blk_nxt;
      r_p         <= w_p_nxt;
      r_len       <= w_len_nxt;
      r_ext_one   <= w_ext_one_nxt;
      r_din_ready <= (w_state_nxt == S_FILL);
      r_blk_valid <= (w_state_nxt != S_FILL);
      r_blk_last  <= (w_state_nxt == S_LAST);
    end
  end

  assign din_ready = r_din_ready;
  assign blk       = r_blk;
  assign blk_valid = r_blk_valid;
  assign blk_last  = r_blk_last;

endmodule
`default_nettype wire
